// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift execute unit: S1 latches operands and shift count,
// S2 registers the rotate/shift/SLBI/BTR result with its dest tag and zero flag.
module shift_exec_stage #(
    parameter int unsigned TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [1:0]       in_op,
    input  logic [15:0]      in_rs,
    input  logic [15:0]      in_rt,
    input  logic [7:0]       in_imm,
    input  logic [TAG_W-1:0] in_dst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [TAG_W-1:0] out_dst,
    output logic             out_zero
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    logic [1:0]       s1_mode;
    logic [1:0]       s1_op;
    logic [DW-1:0]    s1_rs;
    logic [CW-1:0]    s1_cnt;
    logic [7:0]       s1_imm;
    logic [TAG_W-1:0] s1_dst;
    logic             s1_v;
    logic             s2_v;

    logic             adv2;
    logic             accept;
    logic [2*DW-1:0]  rol2;
    logic [2*DW-1:0]  ror2;
    logic [DW-1:0]    shifted;
    logic [DW-1:0]    rev;
    logic [DW-1:0]    result;

    // Ready depends only on pipeline occupancy and out_ready, never on in_valid.
    assign adv2      = s1_v && (!s2_v || out_ready);
    assign in_ready  = !rst && (!s1_v || adv2);
    assign accept    = in_valid && in_ready;
    assign out_valid = s2_v;

    // Operand register; the count is resolved here so S2 only sees 4 bits.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_mode <= in_mode;
            s1_op   <= in_op;
            s1_rs   <= in_rs;
            s1_cnt  <= (in_mode == 2'b00) ? in_rt[CW-1:0] : in_imm[CW-1:0];
            s1_imm  <= in_imm;
            s1_dst  <= in_dst;
        end
    end

    // Rotates come from the doubled operand so one shifter serves both directions.
    always_comb begin
        rol2    = {s1_rs, s1_rs} << s1_cnt;
        ror2    = {s1_rs, s1_rs} >> s1_cnt;
        shifted = s1_rs;
        rev     = '0;
        result  = s1_rs;
        case (s1_op)
            2'b00:   shifted = rol2[2*DW-1:DW];
            2'b01:   shifted = s1_rs << s1_cnt;
            2'b10:   shifted = ror2[DW-1:0];
            default: shifted = s1_rs >> s1_cnt;
        endcase
        for (int i = 0; i < 16; i++) begin
            rev[i] = s1_rs[15-i];
        end
        case (s1_mode)
            2'b10:   result = {s1_rs[7:0], s1_imm};
            2'b11:   result = rev;
            default: result = shifted;
        endcase
    end

    // Valid bits: reset beats flush, flush beats a same-cycle accept.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (accept) begin
                s1_v <= 1'b1;
            end else if (adv2) begin
                s1_v <= 1'b0;
            end
            if (adv2) begin
                s2_v <= 1'b1;
            end else if (out_ready) begin
                s2_v <= 1'b0;
            end
        end
    end

    // Result register holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_dst  <= '0;
            out_zero <= 1'b0;
        end else if (adv2) begin
            out_data <= result;
            out_dst  <= s1_dst;
            out_zero <= (result == '0);
        end
    end

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: expected results are modelled bit-serially
// on acceptance and compared in order as the stage hands them downstream.
module tb_shift_exec_stage;

    localparam int unsigned TAG_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [1:0]       in_op;
    logic [15:0]      in_rs;
    logic [15:0]      in_rt;
    logic [7:0]       in_imm;
    logic [TAG_W-1:0] in_dst;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic [TAG_W-1:0] out_dst;
    logic             out_zero;

    typedef struct packed {
        logic [15:0]      data;
        logic [TAG_W-1:0] dst;
        logic             zero;
    } exp_t;

    exp_t             sbq[$];
    int               errors = 0;
    int               checks = 0;
    logic             acc;
    logic             stall_prev = 1'b0;
    logic [15:0]      held_data;
    logic [TAG_W-1:0] held_dst;

    always #5 clk = ~clk;

    shift_exec_stage #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
        .in_imm(in_imm), .in_dst(in_dst),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_dst(out_dst), .out_zero(out_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: one bit position per step, independent of the RTL's structure.
    function automatic logic [15:0] model(input logic [1:0] mode, input logic [1:0] op,
                                          input logic [15:0] rs, input logic [15:0] rt,
                                          input logic [7:0] imm);
        logic [15:0] r;
        int          cnt;
        cnt = (mode == 2'b00) ? int'(rt[3:0]) : int'(imm[3:0]);
        r = rs;
        if (mode == 2'b10) begin
            r = {rs[7:0], imm};
        end else if (mode == 2'b11) begin
            for (int i = 0; i < 16; i++) r[i] = rs[15-i];
        end else begin
            for (int k = 0; k < cnt; k++) begin
                case (op)
                    2'b00:   r = {r[14:0], r[15]};
                    2'b01:   r = {r[14:0], 1'b0};
                    2'b10:   r = {r[0], r[15:1]};
                    default: r = {1'b0, r[15:1]};
                endcase
            end
        end
        return r;
    endfunction

    // One clock: sample settled signals, update scoreboard, advance to next negedge.
    task automatic cycle();
        exp_t e;
        logic [15:0] d;
        #1;
        acc = 1'b0;
        if (stall_prev) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(held_data));
            check("hold_dst", 32'(out_dst), 32'(held_dst));
        end
        if (rst || flush) begin
            sbq.delete();
            stall_prev = 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_dst", 32'(out_dst), 32'(e.dst));
                    check("out_zero", 32'(out_zero), 32'(e.zero));
                end
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                d = model(in_mode, in_op, in_rs, in_rt, in_imm);
                sbq.push_back('{data: d, dst: in_dst, zero: (d == 16'h0)});
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_dst   = out_dst;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] mode, input logic [1:0] op, input logic [15:0] rs,
                        input logic [15:0] rt, input logic [7:0] imm, input logic [TAG_W-1:0] dst);
        in_mode = mode; in_op = op; in_rs = rs; in_rt = rt; in_imm = imm; in_dst = dst;
        in_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (acc) break;
            if (k >= 3) out_ready = 1'b1;
        end
        check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) cycle();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = '0; in_op = '0; in_rs = '0; in_rt = '0; in_imm = '0; in_dst = '0;
        @(negedge clk);
        cycle(); cycle();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_out_dst", 32'(out_dst), 32'd0);
        rst = 1'b0;
        #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Latency: result appears one edge after the accept edge.
        out_ready = 1'b1;
        send(2'b00, 2'b00, 16'h8001, 16'h0001, 8'h00, 3'd1);
        in_valid = 1'b0;
        #1 check("lat_early", 32'(out_valid), 32'd0);
        cycle();
        check("lat_valid", 32'(out_valid), 32'd1);
        check("t1_data", 32'(out_data), 32'h0003);
        idle(2);

        // Immediate counts, count 0, SLBI, BTR, upper rt bits ignored, SRL to zero.
        send(2'b01, 2'b11, 16'hF000, 16'h0000, 8'h0C, 3'd2);
        send(2'b01, 2'b01, 16'h0001, 16'h0000, 8'h0F, 3'd3);
        send(2'b01, 2'b10, 16'hBEEF, 16'h0000, 8'hF0, 3'd4);
        send(2'b10, 2'b00, 16'h12AB, 16'h0000, 8'hCD, 3'd5);
        send(2'b11, 2'b01, 16'h0001, 16'h0000, 8'h00, 3'd6);
        send(2'b00, 2'b01, 16'h0001, 16'hFFF0, 8'h00, 3'd7);
        send(2'b00, 2'b11, 16'h0001, 16'h0001, 8'h00, 3'd0);
        send(2'b00, 2'b10, 16'h0001, 16'h0001, 8'h00, 3'd1);
        idle(4);
        check("t3_drained", 32'(sbq.size()), 32'd0);

        // Backpressure: two accepts fill both stages, then ready drops while stalled.
        out_ready = 1'b0;
        send(2'b00, 2'b00, 16'h1234, 16'h0004, 8'h00, 3'd4);
        send(2'b01, 2'b11, 16'h8000, 16'h0000, 8'h0F, 3'd5);
        in_mode = 2'b10; in_op = 2'b00; in_rs = 16'h00AA; in_rt = 16'h0; in_imm = 8'h55; in_dst = 3'd6;
        in_valid = 1'b1;
        repeat (3) begin
            #1 check("t4_in_ready", 32'(in_ready), 32'd0);
            cycle();
        end
        out_ready = 1'b1;
        send(2'b10, 2'b00, 16'h00AA, 16'h0000, 8'h55, 3'd6);
        send(2'b11, 2'b00, 16'hC001, 16'h0000, 8'h00, 3'd7);
        idle(4);
        check("t4_drained", 32'(sbq.size()), 32'd0);

        // Flush with both stages full and a new op offered.
        out_ready = 1'b0;
        send(2'b00, 2'b00, 16'h0F0F, 16'h0001, 8'h00, 3'd1);
        send(2'b00, 2'b01, 16'h0F0F, 16'h0002, 8'h00, 3'd2);
        in_mode = 2'b00; in_rs = 16'hFFFF; in_dst = 3'd3; in_valid = 1'b1;
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        #1 check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        idle(4);
        check("flush_no_output", 32'(out_valid), 32'd0);

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        send(2'b01, 2'b00, 16'h00F0, 16'h0000, 8'h04, 3'd4);
        send(2'b01, 2'b00, 16'h00F0, 16'h0000, 8'h08, 3'd5);
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1 check("rst_stall_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall_in_ready", 32'(in_ready), 32'd1);
        check("rst_stall_out_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        idle(4);

        // Random traffic with random backpressure.
        for (int n = 0; n < 120; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'($urandom),
                     16'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            else
                idle(1);
        end
        out_ready = 1'b1;
        idle(8);
        check("final_drained", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
